rle_stream_decoder: RTL and testbench

RLE_STREAM_DECODER -- requirements
Module: rle_stream_decoder

---
 rtl/rle_stream_decoder.sv | 87 ++++++++
 tb/tb_rle_stream_decoder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rle_stream_decoder.sv
// rle_stream_decoder: decodes a header/run-length/symbol word stream into repeated output symbols
module rle_stream_decoder #(
  parameter int DATA_W  = 8,
  parameter int TOTAL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  input  logic               out_ready,
  output logic               idle,
  output logic               finish,
  output logic               zero_run,
  output logic [TOTAL_W-1:0] total
);
  typedef enum logic [2:0] {IDLE, HDR, LEN, SYM, EMIT, DONE} state_t;
  state_t r_state, w_next;
  logic r_in_ready, r_out_valid, r_idle, r_finish, r_zero;
  logic [TOTAL_W-1:0] r_total;
  logic [DATA_W-1:0] r_p, r_r, r_sym;
  logic w_in_hs, w_out_hs, w_last_pair;
  assign w_in_hs     = in_valid && r_in_ready;
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_last_pair = r_p <= DATA_W'(1);
  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_sym;
  assign idle        = r_idle;
  assign finish      = r_finish;
  assign zero_run    = r_zero;
  assign total       = r_total;
  // next state: advance only on the handshake relevant to the current state
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = start ? HDR : r_state;
      HDR:        w_next = !w_in_hs ? HDR : (in_data == '0) ? DONE : LEN;
      LEN:        w_next = w_in_hs ? SYM : LEN;
      SYM:        w_next = !w_in_hs ? SYM : (r_r != '0) ? EMIT : w_last_pair ? DONE : LEN;
      EMIT:       w_next = (w_out_hs && r_r == DATA_W'(1)) ? (w_last_pair ? DONE : LEN) : EMIT;
      default:    w_next = IDLE;
    endcase
  end
  // state, registered status flags and pair/run/total counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_idle      <= 1'b1;
      r_finish    <= 1'b0;
      r_zero      <= 1'b0;
      r_total     <= '0;
      r_p         <= '0;
      r_r         <= '0;
      r_sym       <= '0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= w_next inside {HDR, LEN, SYM};
      r_out_valid <= w_next == EMIT;
      r_idle      <= w_next == IDLE;
      r_finish    <= w_next == DONE;
      if ((r_state == IDLE || r_state == DONE) && start) begin
        r_zero  <= 1'b0;
        r_total <= '0;
      end
      if (r_state == HDR && w_in_hs) r_p <= in_data;
      if (r_state == LEN && w_in_hs) r_r <= in_data;
      if (r_state == SYM && w_in_hs) begin
        r_sym <= in_data;
        if (r_r == '0) begin
          r_zero <= 1'b1;
          r_p    <= r_p - DATA_W'(1);
        end
      end
      if (r_state == EMIT && w_out_hs) begin
        r_r     <= r_r - DATA_W'(1);
        r_total <= r_total + TOTAL_W'(1);
        if (r_r == DATA_W'(1)) r_p <= r_p - DATA_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_rle_stream_decoder.sv
// tb_rle_stream_decoder: scoreboard bench with a run-expansion reference model
module tb_rle_stream_decoder;
  localparam int W = 8;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst = 1, start = 0, in_valid = 0, out_ready = 1;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, idle, finish, zero_run;
  logic [W-1:0] out_data;
  logic [15:0] total;
  rle_stream_decoder #(.DATA_W(W), .TOTAL_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .idle(idle), .finish(finish), .zero_run(zero_run), .total(total));
  logic s_start = 0, s_in_valid = 0, s_out_ready = 1;
  logic [15:0] s_in_data = '0;
  logic s_in_ready, s_out_valid, s_idle, s_finish, s_zero;
  logic [15:0] s_out_data, s_total;
  rle_stream_decoder #(.DATA_W(16), .TOTAL_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_in_valid), .in_data(s_in_data),
    .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data), .out_ready(s_out_ready),
    .idle(s_idle), .finish(s_finish), .zero_run(s_zero), .total(s_total));
  int chk = 0, err = 0, out_cnt = 0, b_cnt = 0, b_err = 0;
  int rmode = 0, pidx = 0, max_gap = 2;
  int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
  logic [W-1:0] exp_q[$];
  logic [W-1:0] runs[$];
  logic [W-1:0] syms[$];
  logic [W-1:0] e, prev_data;
  logic prev_stall = 0;
  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] x);
    chk++;
    if (a !== x) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endtask
  // consumer backpressure: always ready, random, or a fixed toggle pattern from the first EMIT cycle
  always @(posedge clk) begin
    #1;
    if (rmode == 0) out_ready = 1;
    else if (rmode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (pidx < 7 && (out_valid || pidx > 0)) begin
      out_ready = pat[pidx] != 0;
      pidx++;
    end else out_ready = 1;
  end
  // monitor: pops the scoreboard on every output handshake, checks stall hold and in_ready in EMIT
  always @(negedge clk) begin
    if (rst) prev_stall = 0;
    else begin
      if (prev_stall) begin
        chk++;
        if (!out_valid || out_data !== prev_data) begin
          err++;
          $display("FAIL stall_hold: out_valid=%0b out_data=%h expected valid with %h", out_valid, out_data, prev_data);
        end
      end
      if (out_valid) check("in_ready_in_emit", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        chk++;
        if (exp_q.size() == 0) begin
          err++;
          $display("FAIL unexpected_output: got %h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin
            err++;
            $display("FAIL out_data: got %h expected %h", out_data, e);
          end
        end
        out_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end
  always @(negedge clk) begin
    if (!rst && s_out_valid && s_out_ready) begin
      b_cnt++;
      if (s_out_data !== 16'hBEEF) b_err++;
    end
  end
  task automatic send_word(input logic [W-1:0] w);
    int n = 0;
    in_valid = 1;
    in_data = w;
    start = $urandom_range(0, 3) == 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk++;
      err++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 in_valid = 0;
    start = 0;
    repeat ($urandom_range(0, max_gap)) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic run_stream();
    int et = 0, n = 0;
    logic ez = 0;
    foreach (runs[i]) begin
      if (runs[i] == 0) ez = 1;
      for (int k = 0; k < int'(runs[i]); k++) exp_q.push_back(syms[i]);
      et += int'(runs[i]);
    end
    pulse_start();
    send_word(W'(runs.size()));
    foreach (runs[i]) begin
      send_word(runs[i]);
      send_word(syms[i]);
    end
    while (!(finish && exp_q.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("finish", 32'(finish), 1);
    check("queue_empty", exp_q.size(), 0);
    check("total", 32'(total), 32'(16'(et)));
    check("zero_run", 32'(zero_run), 32'(ez));
    exp_q.delete();
  endtask
  task automatic send16(input logic [15:0] w);
    int n = 0;
    s_in_valid = 1;
    s_in_data = w;
    @(negedge clk);
    while (!s_in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!s_in_ready) begin
      chk++;
      err++;
      $display("FAIL in_ready16_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 s_in_valid = 0;
  endtask
  initial begin
    int n, base;
    repeat (3) @(posedge clk);
    #1;
    check("rst_idle", 32'(idle), 1);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_finish", 32'(finish), 0);
    check("rst_zero_run", 32'(zero_run), 0);
    check("rst_total", 32'(total), 0);
    rst = 0;
    runs = '{8'd3, 8'd1};
    syms = '{8'hAA, 8'h55};
    run_stream();
    runs.delete();
    syms.delete();
    run_stream();
    runs = '{8'd0, 8'd2};
    syms = '{8'h11, 8'h22};
    run_stream();
    rmode = 2;
    pidx = 0;
    max_gap = 0;
    runs = '{8'd4};
    syms = '{8'h3C};
    run_stream();
    rmode = 0;
    exp_q = '{8'h77, 8'h77, 8'h77, 8'h77, 8'h77};
    base = out_cnt;
    pulse_start();
    send_word(8'd1);
    send_word(8'd5);
    send_word(8'h77);
    n = 0;
    while (out_cnt < base + 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("outputs_before_rst", out_cnt - base, 2);
    #1 rst = 1;
    @(posedge clk);
    #1;
    check("midrun_rst_idle", 32'(idle), 1);
    check("midrun_rst_out_valid", 32'(out_valid), 0);
    check("midrun_rst_total", 32'(total), 0);
    check("midrun_rst_in_ready", 32'(in_ready), 0);
    exp_q.delete();
    rst = 0;
    max_gap = 2;
    runs = '{8'd2, 8'd1};
    syms = '{8'h5A, 8'hC3};
    run_stream();
    for (int t = 0; t < 10; t++) begin
      rmode = t % 3 == 2 ? 0 : 1;
      runs.delete();
      syms.delete();
      for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
        runs.push_back(W'($urandom_range(0, 6)));
        syms.push_back(W'($urandom_range(0, 255)));
      end
      run_stream();
    end
    rmode = 0;
    @(posedge clk);
    #1 s_start = 1;
    @(posedge clk);
    #1 s_start = 0;
    send16(16'd1);
    send16(16'hFFFF);
    send16(16'hBEEF);
    n = 0;
    while (!s_finish && n < 70000) begin
      @(negedge clk);
      n++;
    end
    check("w16_finish", 32'(s_finish), 1);
    check("w16_outputs", b_cnt, 65535);
    check("w16_bad_data", b_err, 0);
    check("w16_total", 32'(s_total), 32'hFFFF);
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
